// File: rtl/ts4231_emulator.sv
// TS4231 D/E pad responder: S0/SLEEP/WATCH/S3 state, config frames, watch entry.
// Define TS4231_EMU_CFG_CHECK_EN to require cfg_value==EXPECTED_CFG for WATCH entry.
module ts4231_emulator #(
  parameter int unsigned CLK_SPEED    = 50_000_000,
  parameter logic [13:0] RESET_CFG    = 14'h0000,
  parameter logic [13:0] EXPECTED_CFG = 14'h392B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_i,
  input  logic        e_i,
  output logic        d_pull,
  output logic        e_pull,
  output logic        d_oe,
  output logic        d_o,
  output logic        e_oe,
  output logic        e_o,
  input  logic        light_env,
  input  logic        light_data,
  input  logic        sleep_req,
  output logic [2:0]  emu_state,
  output logic [13:0] cfg_value,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    ST_SLEEP = 3'b000,
    ST_WATCH = 3'b001,
    ST_S3    = 3'b010,
    ST_S0    = 3'b011
  } emu_t;

  typedef enum logic [2:0] {
    B_IDLE, B_CMD, B_WR_DATA, B_RD_DATA,
    B_RD_END, B_WAIT_STOP, B_WATCH_SEQ1, B_WATCH_SEQ2
  } bus_t;

  emu_t        st_q, st_n;
  bus_t        bus_q, bus_n;
  logic [3:0]  cnt_q, cnt_n;
  logic [13:0] sh_q, sh_n;
  logic [13:0] cfg_q, cfg_n;
  logic        dmov_q, dmov_n;
  logic [1:0]  unl_q, unl_n;
  logic        err_q, err_n;
  logic        doe_n, do_n, eoe_n, eo_n;
  logic        d_s1, d_s2, d_q, e_s1, e_s2, e_q;
  logic        abort, cfg_ok;
  logic [3:0]  rd_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {d_s1, d_s2, d_q} <= 3'b000;
      {e_s1, e_s2, e_q} <= 3'b000;
    end else begin
      {d_s1, d_s2, d_q} <= {d_i, d_s1, d_s2};
      {e_s1, e_s2, e_q} <= {e_i, e_s1, e_s2};
    end
  end

  logic d_rise, d_fall, e_rise, e_fall, d_edge, e_edge;
  logic start, stop;
  assign d_rise = d_s2 & ~d_q;
  assign d_fall = ~d_s2 & d_q;
  assign e_rise = e_s2 & ~e_q;
  assign e_fall = ~e_s2 & e_q;
  assign d_edge = d_rise | d_fall;
  assign e_edge = e_rise | e_fall;
  assign start  = d_fall & e_s2;
  assign stop   = d_rise & e_s2;
  assign rd_idx = cnt_q - 4'd1;

`ifdef TS4231_EMU_CFG_CHECK_EN
  assign cfg_ok = (cfg_q == EXPECTED_CFG);
`else
  assign cfg_ok = 1'b1;
`endif

  always_comb begin
    st_n   = st_q;
    bus_n  = bus_q;
    cnt_n  = cnt_q;
    sh_n   = sh_q;
    cfg_n  = cfg_q;
    dmov_n = dmov_q;
    unl_n  = unl_q;
    err_n  = err_q;
    doe_n  = d_oe;
    do_n   = d_o;
    eoe_n  = e_oe;
    eo_n   = e_o;
    abort  = 1'b0;
    unique case (st_q)
      ST_S0: begin
        if (e_rise && unl_q != 2'd2) unl_n = unl_q + 2'd1;
        if (d_edge) begin
          unl_n = 2'd0;
          if (d_rise && unl_q == 2'd2) begin
            st_n  = ST_S3;
            bus_n = B_IDLE;
          end
        end
      end
      ST_SLEEP: begin
        if (d_fall && !e_s2) begin
          st_n  = ST_WATCH;
          doe_n = 1'b1;
          eoe_n = 1'b1;
          eo_n  = ~light_env;
          do_n  = light_env & light_data;
        end
      end
      ST_WATCH: begin
        bus_n = B_IDLE;
        if (sleep_req) begin
          st_n  = ST_SLEEP;
          doe_n = 1'b0;
          eoe_n = 1'b0;
          do_n  = 1'b0;
          eo_n  = 1'b0;
        end else begin
          doe_n = 1'b1;
          eoe_n = 1'b1;
          eo_n  = ~light_env;
          do_n  = light_env & light_data;
        end
      end
      ST_S3: begin
        unique case (bus_q)
          B_IDLE: begin
            if (start) begin
              bus_n  = B_CMD;
              dmov_n = 1'b0;
            end else if (e_fall && d_s2) begin
              bus_n = B_WATCH_SEQ1;
            end
          end
          B_CMD, B_WR_DATA: begin
            if (start) begin
              bus_n  = B_CMD;
              dmov_n = 1'b0;
              doe_n  = 1'b0;
            end else if (e_rise) begin
              dmov_n = 1'b0;
              if (bus_q == B_CMD) begin
                cnt_n = 4'd14;
                if (d_s2) begin
                  bus_n = B_RD_DATA;
                  sh_n  = cfg_q;
                end else begin
                  bus_n = B_WR_DATA;
                end
              end else begin
                sh_n  = {sh_q[12:0], d_s2};
                cnt_n = cnt_q - 4'd1;
                if (cnt_q == 4'd1) bus_n = B_WAIT_STOP;
              end
            end else if (d_edge) begin
              // one data change per bit slot, and only while E is low
              if (e_s2 || dmov_q) abort = 1'b1;
              else dmov_n = 1'b1;
            end
          end
          B_RD_DATA: begin
            if (e_rise) begin
              doe_n = 1'b1;
              do_n  = cfg_q[rd_idx];
              cnt_n = cnt_q - 4'd1;
              if (cnt_q == 4'd1) bus_n = B_RD_END;
            end
          end
          B_RD_END: begin
            if (e_fall) begin
              doe_n = 1'b0;
              bus_n = B_WAIT_STOP;
            end else if (e_rise) begin
              abort = 1'b1;
            end
          end
          B_WAIT_STOP: begin
            if (start) begin
              bus_n  = B_CMD;
              dmov_n = 1'b0;
            end else if (stop) begin
              cfg_n = sh_q;
              bus_n = B_IDLE;
            end
          end
          B_WATCH_SEQ1: begin
            if (d_fall && !e_s2) bus_n = B_WATCH_SEQ2;
            else if (d_edge || e_edge) abort = 1'b1;
          end
          B_WATCH_SEQ2: begin
            if (e_rise && !d_s2) begin
              if (cfg_ok) begin
                st_n  = ST_WATCH;
                bus_n = B_IDLE;
                doe_n = 1'b1;
                eoe_n = 1'b1;
                eo_n  = ~light_env;
                do_n  = light_env & light_data;
              end else begin
                abort = 1'b1;
              end
            end else if (d_edge || e_edge) begin
              abort = 1'b1;
            end
          end
          default: bus_n = B_IDLE;
        endcase
      end
      default: st_n = ST_S0;
    endcase
    if (abort) begin
      err_n = 1'b1;
      doe_n = 1'b0;
      bus_n = B_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_S0;
      bus_q  <= B_IDLE;
      cnt_q  <= 4'd0;
      sh_q   <= 14'd0;
      cfg_q  <= RESET_CFG;
      dmov_q <= 1'b0;
      unl_q  <= 2'd0;
      err_q  <= 1'b0;
      d_oe   <= 1'b0;
      d_o    <= 1'b0;
      e_oe   <= 1'b0;
      e_o    <= 1'b0;
    end else begin
      st_q   <= st_n;
      bus_q  <= bus_n;
      cnt_q  <= cnt_n;
      sh_q   <= sh_n;
      cfg_q  <= cfg_n;
      dmov_q <= dmov_n;
      unl_q  <= unl_n;
      err_q  <= err_n;
      d_oe   <= doe_n;
      d_o    <= do_n;
      e_oe   <= eoe_n;
      e_o    <= eo_n;
    end
  end

  always_comb begin
    {d_pull, e_pull} = 2'b00;
    unique case (st_q)
      ST_SLEEP: {d_pull, e_pull} = 2'b10;
      ST_WATCH: {d_pull, e_pull} = 2'b01;
      ST_S3:    {d_pull, e_pull} = 2'b11;
      default:  {d_pull, e_pull} = 2'b00;
    endcase
  end

  assign emu_state = st_q;
  assign cfg_value = cfg_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ts4231_emulator.sv
// Bench for ts4231_emulator: host bus frames, watch/sleep, light vectors.
// Expected values come from constants, a vector table and scoreboard queues.
module tb_ts4231_emulator;

  localparam int W = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_i, e_i;
  logic        d_pull, e_pull, d_oe, d_o, e_oe, e_o;
  logic        light_env, light_data, sleep_req;
  logic [2:0]  emu_state;
  logic [13:0] cfg_value;
  logic        frame_err;

  logic h_d_en, h_e_en, h_d, h_e;

  int checks = 0;
  int errors = 0;

  logic       rd_q[$];
  logic [1:0] sb_q[$];

  typedef struct packed {
    logic env;
    logic data;
    logic eo;
    logic dout;
  } vec_t;

  vec_t vt[5];

  ts4231_emulator dut (
    .clk(clk), .rst(rst),
    .d_i(d_i), .e_i(e_i),
    .d_pull(d_pull), .e_pull(e_pull),
    .d_oe(d_oe), .d_o(d_o),
    .e_oe(e_oe), .e_o(e_o),
    .light_env(light_env), .light_data(light_data),
    .sleep_req(sleep_req),
    .emu_state(emu_state),
    .cfg_value(cfg_value),
    .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  assign d_i = d_oe ? d_o : (h_d_en ? h_d : d_pull);
  assign e_i = e_oe ? e_o : (h_e_en ? h_e : e_pull);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hs(input logic e, input logic d);
    h_e = e;
    h_d = d;
    step(W);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    h_d_en = 1'b0;
    h_e_en = 1'b0;
    step(2);
    rst = 1'b0;
    step(100);
  endtask

  task automatic unlock();
    int n;
    h_e = 1'b0;
    h_d = 1'b0;
    h_e_en = 1'b1;
    h_d_en = 1'b1;
    step(W);
    hs(1, 0);
    hs(0, 0);
    hs(1, 0);
    h_d = 1'b1;
    n = 0;
    while (n < 4 && emu_state != 3'b010) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("unlock_state", emu_state, 3'b010);
    step(W);
  endtask

  task automatic write_frame(input logic [13:0] v);
    hs(1, 0);
    hs(0, 0);
    hs(0, 0);
    hs(1, 0);
    for (int i = 13; i >= 0; i--) begin
      hs(0, h_d);
      hs(0, v[i]);
      hs(1, v[i]);
    end
    hs(0, h_d);
    hs(0, 0);
    hs(1, 0);
    hs(1, 1);
  endtask

  task automatic go_watch();
    hs(0, 1);
    hs(0, 0);
    hs(1, 0);
    h_d_en = 1'b0;
    h_e_en = 1'b0;
    step(5);
  endtask

  logic [13:0] exp_cfg;
  logic [1:0]  exp2;
  logic        rb;

  initial begin
    rst = 1'b1;
    h_d_en = 1'b0;
    h_e_en = 1'b0;
    h_d = 1'b0;
    h_e = 1'b0;
    light_env = 1'b0;
    light_data = 1'b0;
    sleep_req = 1'b0;
    vt[0] = '{env: 1'b1, data: 1'b1, eo: 1'b0, dout: 1'b1};
    vt[1] = '{env: 1'b1, data: 1'b0, eo: 1'b0, dout: 1'b0};
    vt[2] = '{env: 1'b0, data: 1'b1, eo: 1'b1, dout: 1'b0};
    vt[3] = '{env: 1'b1, data: 1'b1, eo: 1'b0, dout: 1'b1};
    vt[4] = '{env: 1'b0, data: 1'b0, eo: 1'b1, dout: 1'b0};

    do_reset();
    chk("rst_state", emu_state, 3'b011);
    chk("rst_pulls", {d_pull, e_pull}, 2'b00);
    chk("rst_oe", {d_oe, e_oe}, 2'b00);
    chk("rst_err", frame_err, 1'b0);
    chk("rst_cfg", cfg_value, 14'h0000);

    unlock();
    chk("s3_pulls", {d_pull, e_pull}, 2'b11);

    exp_cfg = 14'h392B;
    write_frame(exp_cfg);
    chk("wr_cfg", cfg_value, exp_cfg);
    chk("wr_err", frame_err, 1'b0);

    hs(1, 0);
    hs(0, 0);
    hs(0, 1);
    hs(1, 1);
    hs(0, 1);
    h_d_en = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      h_e = 1'b1;
      rd_q.push_back(exp_cfg[i]);
      step(W);
      rb = rd_q.pop_front();
      chk($sformatf("rd_bit%0d", i), d_i, rb);
      h_e = 1'b0;
      step(W);
    end
    chk("rd_oe_off", d_oe, 1'b0);
    h_d = d_i;
    h_d_en = 1'b1;
    hs(0, 0);
    hs(1, 0);
    hs(1, 1);
    chk("rd_cfg_kept", cfg_value, exp_cfg);
    chk("rd_err", frame_err, 1'b0);

    hs(1, 0);
    hs(0, 0);
    hs(0, 0);
    hs(1, 0);
    for (int i = 0; i < 3; i++) begin
      hs(0, h_d);
      hs(0, 1);
      hs(1, 1);
    end
    hs(0, 1);
    hs(0, 0);
    hs(0, 1);
    chk("abort_err", frame_err, 1'b1);
    chk("abort_cfg", cfg_value, exp_cfg);
    hs(1, 1);

    go_watch();
    chk("watch_state", emu_state, 3'b001);
    chk("watch_oe", {d_oe, e_oe}, 2'b11);

    for (int i = 0; i < 5; i++) begin
      light_env = vt[i].env;
      light_data = vt[i].data;
      sb_q.push_back({vt[i].eo, vt[i].dout});
      step(1);
      exp2 = sb_q.pop_front();
      chk($sformatf("vec%0d_eo", i), e_o, exp2[1]);
      chk($sformatf("vec%0d_do", i), d_o, exp2[0]);
    end

    sleep_req = 1'b1;
    step(1);
    sleep_req = 1'b0;
    chk("sleep_state", emu_state, 3'b000);
    chk("sleep_pulls", {d_pull, e_pull}, 2'b10);
    chk("sleep_oe", {d_oe, e_oe}, 2'b00);

    sleep_req = 1'b1;
    step(1);
    sleep_req = 1'b0;
    chk("sleep_ignored", emu_state, 3'b000);

    h_e = 1'b0;
    h_d = 1'b1;
    h_e_en = 1'b1;
    h_d_en = 1'b1;
    step(W);
    hs(0, 0);
    chk("sleep_to_watch", emu_state, 3'b001);
    h_e_en = 1'b0;
    h_d_en = 1'b0;
    step(5);

    rst = 1'b1;
    #1;
    chk("async_rst_oe", {d_oe, e_oe}, 2'b00);
    chk("async_rst_state", emu_state, 3'b011);
    step(2);
    rst = 1'b0;
    step(100);
    chk("rst2_err", frame_err, 1'b0);
    chk("rst2_cfg", cfg_value, 14'h0000);

    unlock();
    write_frame(14'h0001);
    chk("wr2_cfg", cfg_value, 14'h0001);
    go_watch();
`ifdef TS4231_EMU_CFG_CHECK_EN
    chk("cfgchk_state", emu_state, 3'b010);
    chk("cfgchk_err", frame_err, 1'b1);
`else
    chk("cfgchk_state", emu_state, 3'b001);
    chk("cfgchk_err", frame_err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_600_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
